// File: rtl/exception_csr_unit_pkg.sv
// Shared CSR addresses, mstatus bit positions and FSM state type
// for the machine-mode trap/CSR unit.
package exc_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // MPP is hardwired to machine mode
    localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;

    typedef enum logic {
        EXC_IDLE,
        EXC_REDIRECT
    } exc_state_t;

endpackage

// File: rtl/exception_csr_unit_csr_counter64.sv
// 64-bit counter with increment enable and independently writable halves;
// any write suppresses the increment for that cycle.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 64'd0;
        end else if (we_lo_i || we_hi_i) begin
            if (we_lo_i) count_q[31:0]  <= wdata_i;
            if (we_hi_i) count_q[63:32] <= wdata_i;
        end else if (inc_i) begin
            count_q <= count_q + 64'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/exception_csr_unit.sv
// Machine-mode trap/CSR unit: exception capture, mret, fetch redirect and CSR port.
// Optional mcycle/minstret counters built when EXC_CSR_COUNTERS_EN is defined.
//   state        | meaning
//   EXC_IDLE     | accepting exceptions and mret
//   EXC_REDIRECT | redirect pulse driven this cycle; exceptions still accepted
module exception_csr_unit
    import exc_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exc_occured_i,
    input  logic [31:0] exc_mepc_i,
    input  logic [31:0] exc_mcause_i,
    input  logic [31:0] exc_mtval_i,
    input  logic        mret_i,
    input  logic        retire_i,
    input  logic [11:0] csr_addr_i,
    input  logic        csr_we_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    exc_state_t  state_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;

    logic        mie_q,      mie_d;
    logic        mpie_q,     mpie_d;
    logic [31:2] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:2] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;
    logic [31:0] mtval_q,    mtval_d;

    logic exc_take;
    logic mret_take;

    assign exc_take  = exc_occured_i;
    assign mret_take = mret_i && !exc_occured_i && (state_q == EXC_IDLE);

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;

        if (csr_we_i) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mie_d  = csr_wdata_i[MSTATUS_MIE];
                    mpie_d = csr_wdata_i[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_d    = csr_wdata_i[31:2];
                CSR_MSCRATCH: mscratch_d = csr_wdata_i;
                CSR_MEPC:     mepc_d     = csr_wdata_i[31:2];
                CSR_MCAUSE:   mcause_d   = csr_wdata_i;
                CSR_MTVAL:    mtval_d    = csr_wdata_i;
                default: ;
            endcase
        end

        // Trap/mret updates override a colliding software write
        if (exc_take) begin
            mepc_d   = exc_mepc_i[31:2];
            mcause_d = exc_mcause_i;
            mtval_d  = exc_mtval_i;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_take) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET[31:2];
            mscratch_q <= 32'd0;
            mepc_q     <= 30'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= EXC_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else if (exc_take) begin
            state_q          <= EXC_REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= {mtvec_q, 2'b00};
        end else if (mret_take) begin
            state_q          <= EXC_REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= {mepc_q, 2'b00};
        end else begin
            state_q          <= EXC_IDLE;
            redirect_valid_q <= 1'b0;
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign busy_o           = exc_occured_i || mret_i || (state_q == EXC_REDIRECT);

`ifdef EXC_CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;

    csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (1'b1),
        .we_lo_i (csr_we_i && (csr_addr_i == CSR_MCYCLE)),
        .we_hi_i (csr_we_i && (csr_addr_i == CSR_MCYCLEH)),
        .wdata_i (csr_wdata_i),
        .count_o (mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (retire_i),
        .we_lo_i (csr_we_i && (csr_addr_i == CSR_MINSTRET)),
        .we_hi_i (csr_we_i && (csr_addr_i == CSR_MINSTRETH)),
        .wdata_i (csr_wdata_i),
        .count_o (minstret)
    );

    logic unused_ok;
    assign unused_ok = ^exc_mepc_i[1:0];
`else
    logic unused_ok;
    assign unused_ok = ^{retire_i, exc_mepc_i[1:0]};
`endif

    always_comb begin
        csr_rdata_o = 32'd0;
        case (csr_addr_i)
            CSR_MSTATUS: begin
                csr_rdata_o               = MSTATUS_MPP_M;
                csr_rdata_o[MSTATUS_MIE]  = mie_q;
                csr_rdata_o[MSTATUS_MPIE] = mpie_q;
            end
            CSR_MTVEC:     csr_rdata_o = {mtvec_q, 2'b00};
            CSR_MSCRATCH:  csr_rdata_o = mscratch_q;
            CSR_MEPC:      csr_rdata_o = {mepc_q, 2'b00};
            CSR_MCAUSE:    csr_rdata_o = mcause_q;
            CSR_MTVAL:     csr_rdata_o = mtval_q;
`ifdef EXC_CSR_COUNTERS_EN
            CSR_MCYCLE:    csr_rdata_o = mcycle[31:0];
            CSR_MCYCLEH:   csr_rdata_o = mcycle[63:32];
            CSR_MINSTRET:  csr_rdata_o = minstret[31:0];
            CSR_MINSTRETH: csr_rdata_o = minstret[63:32];
`endif
            default:       csr_rdata_o = 32'd0;
        endcase
    end

endmodule
